// File: rtl/tx_frame_seq_pkg.sv
// Shared definitions for the TX frame sequencer: XGMII control codes, FSM
// encoding, timestamp layout and the lane-4 timestamp adder/normaliser.
package tx_frame_seq_pkg;

    localparam logic [7:0]  XGMII_START = 8'hFB;
    localparam logic [7:0]  XGMII_TERM  = 8'hFD;
    localparam logic [7:0]  XGMII_ERR   = 8'hFE;
    localparam logic [7:0]  XGMII_IDLE  = 8'h07;
    localparam logic [31:0] SC2NS       = 32'd1_000_000_000;
    localparam logic [10:0] BASE_SOF4   = 11'h7FC;
    localparam int          TS_ENTRY_W  = 116;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SOF4  = 2'd1,
        ST_FRAME = 2'd2,
        ST_ABORT = 2'd3
    } seq_state_e;

    typedef struct packed {
        logic [47:0] s;
        logic [31:0] ns;
        logic [15:0] frac;
    } ts_t;

    // Adds adj (ns * 2^16) to {ns, frac} and carries into seconds past 10^9 ns.
    function automatic ts_t ts_add_norm(input ts_t t, input logic [47:0] adj);
        logic [47:0] fns;
        ts_t         r;
        fns    = {t.ns, t.frac} + adj;
        r.frac = fns[15:0];
        if (fns[47:16] >= SC2NS) begin
            r.ns = fns[47:16] - SC2NS;
            r.s  = t.s + 48'd1;
        end else begin
            r.ns = fns[47:16];
            r.s  = t.s;
        end
        return r;
    endfunction

endpackage

// File: rtl/tx_frame_seq_if.sv
// XGMII TX stream plus the two-step timestamp readout port of the sequencer.
interface tx_frame_seq_if;

    logic [63:0]  txd_i;
    logic [7:0]   txc_i;
    // Readout handshake: the head entry is popped on an enabled tx_clk edge
    // where ts_valid_o and ts_rd_i are both high; ts_rd_i while empty is ignored.
    logic         ts_valid_o;
    logic [115:0] ts_data_o;
    logic         ts_rd_i;
    logic [4:0]   ts_count_o;
    logic         ts_ovf_o;
    logic         ts_ovf_clr_i;

    modport master (
        output txd_i, txc_i, ts_rd_i, ts_ovf_clr_i,
        input  ts_valid_o, ts_data_o, ts_count_o, ts_ovf_o
    );

    modport slave (
        input  txd_i, txc_i, ts_rd_i, ts_ovf_clr_i,
        output ts_valid_o, ts_data_o, ts_count_o, ts_ovf_o
    );

endinterface

// File: rtl/tx_frame_seq_ts_sync_fifo.sv
// Synchronous shift-style timestamp FIFO: entry 0 is always the head, so the
// head output comes straight from a register. Sticky overflow on dropped push.
module ts_sync_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 116
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             ovf_clr,
    output logic             valid,
    output logic [WIDTH-1:0] head,
    output logic [4:0]       count,
    output logic             ovf
);

    localparam logic [4:0] DEPTH_C = 5'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [4:0]       count_q, count_d;
    logic             ovf_q, ovf_d;
    logic             full, do_pop, do_push;
    logic [4:0]       wr_idx;

    always_comb begin
        full    = (count_q == DEPTH_C);
        do_pop  = en & pop & (count_q != 5'd0);
        // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
        do_push = en & push & (~full | do_pop);
        wr_idx  = count_q - 5'(do_pop);
        mem_d   = mem_q;
        if (do_pop) begin
            for (int i = 0; i < DEPTH - 1; i++) mem_d[i] = mem_q[i+1];
            mem_d[DEPTH-1] = '0;
        end
        if (do_push) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (wr_idx == 5'(i)) mem_d[i] = push_data;
            end
        end
        count_d = count_q + 5'(do_push) - 5'(do_pop);
        ovf_d   = ovf_q;
        if (en & ovf_clr) ovf_d = 1'b0;
        if (en & push & full & ~do_pop) ovf_d = 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
            count_q <= 5'd0;
            ovf_q   <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    assign valid = (count_q != 5'd0);
    assign head  = mem_q[0];
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule

// File: rtl/tx_frame_seq.sv
// Per-frame PTP TX sequencer: tracks start/SFD/terminate on 64-bit XGMII, drives
// the byte base and SFD pulse, latches the SFD timestamp and queues two-step stamps.
module tx_frame_seq
    import tx_frame_seq_pkg::*;
#(
    parameter int          TS_FIFO_DEPTH = 4,
    parameter int unsigned LANE4_ADJ_FNS = 209715,
    parameter logic [10:0] MAX_BASE      = 11'h7F8
) (
    input  logic         tx_clk,
    input  logic         tx_rst_n,
    input  logic         tx_clk_en_i,
    tx_frame_seq_if.slave bus,
    input  logic [79:0]  rtc_time_i,
    input  logic [15:0]  rtc_frac_ns_i,
    input  logic [31:0]  tsu_cfg_i,
    input  logic         is_ptp_message_i,
    input  logic [3:0]   ptp_messageType_i,
    input  logic [15:0]  ptp_flagField_i,
    input  logic [15:0]  ptp_sequenceId_i,
    output logic [10:0]  eth_count_base_o,
    output logic         get_sfd_done_o,
    output logic         frame_active_o,
    output logic [79:0]  sfd_timestamp_o,
    output logic [15:0]  sfd_timestamp_frac_ns_o,
    output logic         frame_err_o,
    output seq_state_e   dbg_state_o
);

    seq_state_e  state_q, state_d;
    logic [10:0] base_q, base_d;
    logic        sat_q, sat_d;
    logic        sfd_q, sfd_d;
    logic        err_q, err_d;
    logic        active_q, active_d;
    ts_t         ts_q, ts_d;

    logic        start0, start4, any_term, any_err, all_idle;
    logic        one_step, push;
    logic [11:0] base_sum;
    ts_t         rtc_now, rtc_adj;

    logic                  fifo_valid, fifo_ovf;
    logic [TS_ENTRY_W-1:0] fifo_head;
    logic [4:0]            fifo_count;

    assign rtc_now = {rtc_time_i, rtc_frac_ns_i};
    assign rtc_adj = ts_add_norm(rtc_now, 48'(LANE4_ADJ_FNS));

    always_comb begin
        start0   = bus.txc_i[0] && (bus.txd_i[7:0]   == XGMII_START);
        start4   = bus.txc_i[4] && (bus.txd_i[39:32] == XGMII_START);
        any_term = 1'b0;
        any_err  = 1'b0;
        all_idle = (bus.txc_i == 8'hFF);
        for (int i = 0; i < 8; i++) begin
            if (bus.txc_i[i] && bus.txd_i[8*i +: 8] == XGMII_TERM) any_term = 1'b1;
            if (bus.txc_i[i] && bus.txd_i[8*i +: 8] == XGMII_ERR)  any_err  = 1'b1;
            if (bus.txd_i[8*i +: 8] != XGMII_IDLE) all_idle = 1'b0;
        end
    end

    always_comb begin
        one_step = tsu_cfg_i[0] |
                   (tsu_cfg_i[24] & ~ptp_flagField_i[9] &
                    (ptp_messageType_i == 4'd0 || ptp_messageType_i == 4'd3));
        base_sum = {1'b0, base_q} + 12'd8;
        state_d  = state_q;
        base_d   = base_q;
        sat_d    = sat_q;
        ts_d     = ts_q;
        sfd_d    = 1'b0;
        err_d    = 1'b0;
        push     = 1'b0;
        if (tx_clk_en_i) begin
            case (state_q)
                ST_IDLE: begin
                    if (start0) begin
                        state_d = ST_FRAME;
                        base_d  = 11'd0;
                        sat_d   = 1'b0;
                        sfd_d   = 1'b1;
                        ts_d    = rtc_now;
                    end else if (start4) begin
                        state_d = ST_SOF4;
                        ts_d    = rtc_adj;
                    end
                end
                ST_SOF4: begin
                    state_d = ST_FRAME;
                    base_d  = BASE_SOF4;
                    sat_d   = 1'b0;
                    sfd_d   = 1'b1;
                end
                ST_FRAME: begin
                    if (any_err) begin
                        state_d = ST_ABORT;
                        err_d   = 1'b1;
                    end else if (any_term) begin
                        state_d = ST_IDLE;
                        push    = is_ptp_message_i & (ptp_messageType_i <= 4'd3) & ~one_step;
                    end else if (start0) begin
                        err_d   = 1'b1;
                        base_d  = 11'd0;
                        sat_d   = 1'b0;
                        sfd_d   = 1'b1;
                        ts_d    = rtc_now;
                    end else if (start4) begin
                        err_d   = 1'b1;
                        state_d = ST_SOF4;
                        ts_d    = rtc_adj;
                    end else if (!sat_q) begin
                        // Bases above MAX_BASE only occur as the -4 lane-4 start, which must wrap.
                        if (base_q <= MAX_BASE && base_sum > {1'b0, MAX_BASE}) begin
                            base_d = MAX_BASE;
                            sat_d  = 1'b1;
                            err_d  = 1'b1;
                        end else begin
                            base_d = base_sum[10:0];
                        end
                    end
                end
                ST_ABORT: begin
                    if (any_term || all_idle) state_d = ST_IDLE;
                end
                default: state_d = ST_IDLE;
            endcase
        end
        active_d = (state_d == ST_FRAME);
    end

    // Pulse flops are not held by the enable, so each pulse lasts one tx_clk.
    always_ff @(posedge tx_clk or negedge tx_rst_n) begin
        if (!tx_rst_n) begin
            state_q  <= ST_IDLE;
            base_q   <= 11'd0;
            sat_q    <= 1'b0;
            sfd_q    <= 1'b0;
            err_q    <= 1'b0;
            active_q <= 1'b0;
            ts_q     <= '0;
        end else begin
            state_q  <= state_d;
            base_q   <= base_d;
            sat_q    <= sat_d;
            sfd_q    <= sfd_d;
            err_q    <= err_d;
            active_q <= active_d;
            ts_q     <= ts_d;
        end
    end

    ts_sync_fifo #(
        .DEPTH (TS_FIFO_DEPTH),
        .WIDTH (TS_ENTRY_W)
    ) u_ts_fifo (
        .clk       (tx_clk),
        .rst_n     (tx_rst_n),
        .en        (tx_clk_en_i),
        .push      (push),
        .push_data ({ptp_sequenceId_i, ptp_messageType_i, ts_q}),
        .pop       (bus.ts_rd_i),
        .ovf_clr   (bus.ts_ovf_clr_i),
        .valid     (fifo_valid),
        .head      (fifo_head),
        .count     (fifo_count),
        .ovf       (fifo_ovf)
    );

    assign bus.ts_valid_o          = fifo_valid;
    assign bus.ts_data_o           = fifo_head;
    assign bus.ts_count_o          = fifo_count;
    assign bus.ts_ovf_o            = fifo_ovf;
    assign eth_count_base_o        = base_q;
    assign get_sfd_done_o          = sfd_q;
    assign frame_active_o          = active_q;
    assign frame_err_o             = err_q;
    assign sfd_timestamp_o         = {ts_q.s, ts_q.ns};
    assign sfd_timestamp_frac_ns_o = ts_q.frac;
    assign dbg_state_o             = state_q;

endmodule

// File: tb/tb_tx_frame_seq.sv
// Directed bench for tx_frame_seq: frame framing, lane-4 timestamp correction,
// two-step FIFO queueing/overflow, abort/restart, saturation and reset.
module tb_tx_frame_seq;
  import tx_frame_seq_pkg::*;

  localparam logic [63:0] W_IDLE = {8{8'h07}};
  localparam logic [63:0] W_S0   = 64'hD5555555_555555FB;
  localparam logic [63:0] W_S4   = 64'h555555FB_07070707;
  localparam logic [63:0] W_SFD4 = 64'hA1A2A3A4_D5555555;
  localparam logic [63:0] W_TERM = 64'h07070707_070707FD;
  localparam logic [63:0] W_ERR  = 64'h11223344_FE667788;

  // clock / reset
  logic tx_clk = 1'b0;
  logic tx_rst_n = 1'b0;
  logic tx_clk_en_i = 1'b1;
  always #5 tx_clk = ~tx_clk;

  logic [79:0] rtc_time_i = '0;
  logic [15:0] rtc_frac_ns_i = '0;
  logic [31:0] tsu_cfg_i = '0;
  logic        is_ptp_message_i = 1'b0;
  logic [3:0]  ptp_messageType_i = '0;
  logic [15:0] ptp_flagField_i = '0;
  logic [15:0] ptp_sequenceId_i = '0;
  logic [10:0] eth_count_base_o;
  logic        get_sfd_done_o, frame_active_o, frame_err_o;
  logic [79:0] sfd_timestamp_o;
  logic [15:0] sfd_timestamp_frac_ns_o;
  seq_state_e  dbg_state_o;

  tx_frame_seq_if bus();

  tx_frame_seq dut (
    .tx_clk                  (tx_clk),
    .tx_rst_n                (tx_rst_n),
    .tx_clk_en_i             (tx_clk_en_i),
    .bus                     (bus),
    .rtc_time_i              (rtc_time_i),
    .rtc_frac_ns_i           (rtc_frac_ns_i),
    .tsu_cfg_i               (tsu_cfg_i),
    .is_ptp_message_i        (is_ptp_message_i),
    .ptp_messageType_i       (ptp_messageType_i),
    .ptp_flagField_i         (ptp_flagField_i),
    .ptp_sequenceId_i        (ptp_sequenceId_i),
    .eth_count_base_o        (eth_count_base_o),
    .get_sfd_done_o          (get_sfd_done_o),
    .frame_active_o          (frame_active_o),
    .sfd_timestamp_o         (sfd_timestamp_o),
    .sfd_timestamp_frac_ns_o (sfd_timestamp_frac_ns_o),
    .frame_err_o             (frame_err_o),
    .dbg_state_o             (dbg_state_o)
  );

  // scoreboard
  int checks = 0;
  int failures = 0;
  logic [115:0] exp_q[$];

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s obs=0x%0h exp=0x%0h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input logic [63:0] d, input logic [7:0] c);
    @(negedge tx_clk);
    bus.txd_i = d;
    bus.txc_i = c;
    @(posedge tx_clk);
    #1;
  endtask

  task automatic data_word();
    cyc({$urandom, $urandom}, 8'h00);
  endtask

  task automatic set_rtc(input logic [47:0] s, input logic [31:0] ns, input logic [15:0] frac);
    rtc_time_i = {s, ns};
    rtc_frac_ns_i = frac;
  endtask

  task automatic run_frame(input int n_data);
    cyc(W_S0, 8'h01);
    repeat (n_data) data_word();
    cyc(W_TERM, 8'hFF);
  endtask

  function automatic logic [115:0] entry(input logic [15:0] seq, input logic [3:0] typ,
                                         input logic [47:0] s, input logic [31:0] ns,
                                         input logic [15:0] frac);
    return {seq, typ, s, ns, frac};
  endfunction

  task automatic drain_and_compare(input string tag);
    int n;
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      check({tag, "_valid"}, bus.ts_valid_o, 1'b1);
      check({tag, "_head"}, bus.ts_data_o, exp_q.pop_front());
      bus.ts_rd_i = 1'b1;
      cyc(W_IDLE, 8'hFF);
      bus.ts_rd_i = 1'b0;
    end
    check({tag, "_empty_count"}, bus.ts_count_o, 5'd0);
    check({tag, "_empty_valid"}, bus.ts_valid_o, 1'b0);
  endtask

  logic [31:0] t_cfg [8];
  logic [3:0]  t_typ [8];
  logic [15:0] t_flag [8];
  bit          t_push [8];
  int          err_cnt;

  initial begin
    #1_000_000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.txd_i = W_IDLE;
    bus.txc_i = 8'hFF;
    bus.ts_rd_i = 1'b0;
    bus.ts_ovf_clr_i = 1'b0;

    // reset state
    repeat (3) @(posedge tx_clk);
    #1;
    check("rst_base", eth_count_base_o, 11'd0);
    check("rst_sfd", get_sfd_done_o, 1'b0);
    check("rst_active", frame_active_o, 1'b0);
    check("rst_ts", {sfd_timestamp_o, sfd_timestamp_frac_ns_o}, 96'd0);
    check("rst_valid", bus.ts_valid_o, 1'b0);
    check("rst_count", bus.ts_count_o, 5'd0);
    check("rst_ovf", bus.ts_ovf_o, 1'b0);
    check("rst_state", dbg_state_o, ST_IDLE);
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    cyc(W_IDLE, 8'hFF);

    // lane-0 start, 64-byte frame
    set_rtc(48'h1, 32'd500, 16'hABCD);
    cyc(W_S0, 8'h01);
    check("l0_sfd", get_sfd_done_o, 1'b1);
    check("l0_base0", eth_count_base_o, 11'd0);
    check("l0_active", frame_active_o, 1'b1);
    check("l0_ts", sfd_timestamp_o, {48'h1, 32'd500});
    check("l0_frac", sfd_timestamp_frac_ns_o, 16'hABCD);
    set_rtc(48'h2, 32'd777, 16'h0000);
    for (int k = 1; k <= 7; k++) begin
      data_word();
      check("l0_base", eth_count_base_o, 11'(8 * k));
      check("l0_sfd_once", get_sfd_done_o, 1'b0);
    end
    data_word();
    check("l0_active_last", frame_active_o, 1'b1);
    cyc(W_TERM, 8'hFF);
    check("l0_active_drop", frame_active_o, 1'b0);
    check("l0_ts_hold", sfd_timestamp_o, {48'h1, 32'd500});
    check("l0_state_idle", dbg_state_o, ST_IDLE);
    check("l0_no_push", bus.ts_count_o, 5'd0);

    // lane-4 start with ns rollover: 999999999 + 3.2ns + 0xF000 frac
    set_rtc(48'h10, 32'd999_999_999, 16'hF000);
    cyc(W_S4, 8'h1F);
    check("l4_state", dbg_state_o, ST_SOF4);
    check("l4_sfd_early", get_sfd_done_o, 1'b0);
    cyc(W_SFD4, 8'h00);
    check("l4_sfd", get_sfd_done_o, 1'b1);
    check("l4_base0", eth_count_base_o, 11'h7FC);
    check("l4_ts", sfd_timestamp_o, {48'h11, 32'd3});
    check("l4_frac", sfd_timestamp_frac_ns_o, 16'h2333);
    data_word();
    check("l4_base1", eth_count_base_o, 11'h004);
    cyc(W_TERM, 8'hFF);

    // two-step Sync x5 into a depth-4 FIFO
    tsu_cfg_i = 32'h0;
    is_ptp_message_i = 1'b1;
    ptp_messageType_i = 4'd0;
    ptp_flagField_i = 16'h0200;
    ptp_sequenceId_i = 16'h1234;
    for (int i = 0; i < 5; i++) begin
      set_rtc(48'h20 + 48'(i), 32'd1000 + 32'(i), 16'h10 + 16'(i));
      run_frame(2);
      if (i < 4) exp_q.push_back(entry(16'h1234, 4'd0, 48'h20 + 48'(i), 32'd1000 + 32'(i), 16'h10 + 16'(i)));
    end
    check("ts_count_full", bus.ts_count_o, 5'd4);
    check("ts_ovf_set", bus.ts_ovf_o, 1'b1);
    check("ts_head_seq", bus.ts_data_o[115:100], 16'h1234);
    check("ts_head", bus.ts_data_o, exp_q[0]);
    bus.ts_ovf_clr_i = 1'b1;
    cyc(W_IDLE, 8'hFF);
    bus.ts_ovf_clr_i = 1'b0;
    check("ts_ovf_clr", bus.ts_ovf_o, 1'b0);

    // pop and push on the same edge while full
    set_rtc(48'h30, 32'd2000, 16'h0055);
    ptp_sequenceId_i = 16'h4321;
    cyc(W_S0, 8'h01);
    data_word();
    bus.ts_rd_i = 1'b1;
    cyc(W_TERM, 8'hFF);
    bus.ts_rd_i = 1'b0;
    void'(exp_q.pop_front());
    exp_q.push_back(entry(16'h4321, 4'd0, 48'h30, 32'd2000, 16'h0055));
    check("pp_count", bus.ts_count_o, 5'd4);
    check("pp_no_ovf", bus.ts_ovf_o, 1'b0);
    drain_and_compare("pp_drain");
    bus.ts_rd_i = 1'b1;
    cyc(W_IDLE, 8'hFF);
    bus.ts_rd_i = 1'b0;
    check("pop_empty_count", bus.ts_count_o, 5'd0);

    // one-step / message-type push table
    t_cfg  = '{32'h1, 32'h0, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0100_0000, 32'h0, 32'h0};
    t_typ  = '{4'd0, 4'd8, 4'd0, 4'd3, 4'd1, 4'd0, 4'd3, 4'd4};
    t_flag = '{16'h0200, 16'h0200, 16'h0000, 16'h0000, 16'h0000, 16'h0200, 16'h0000, 16'h0000};
    t_push = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 8; i++) begin
      tsu_cfg_i = t_cfg[i];
      ptp_messageType_i = t_typ[i];
      ptp_flagField_i = t_flag[i];
      ptp_sequenceId_i = 16'h0100 + 16'(i);
      set_rtc(48'h40 + 48'(i), 32'd3000 + 32'(i), 16'h20 + 16'(i));
      run_frame(1);
      if (t_push[i]) exp_q.push_back(entry(16'h0100 + 16'(i), t_typ[i], 48'h40 + 48'(i),
                                           32'd3000 + 32'(i), 16'h20 + 16'(i)));
      check("tbl_count", bus.ts_count_o, 5'(exp_q.size()));
    end
    drain_and_compare("tbl_drain");

    // /E/ mid-frame aborts without a push
    tsu_cfg_i = 32'h0;
    ptp_messageType_i = 4'd0;
    ptp_flagField_i = 16'h0200;
    ptp_sequenceId_i = 16'h5555;
    set_rtc(48'h50, 32'd4000, 16'h0066);
    cyc(W_S0, 8'h01);
    data_word();
    cyc(W_ERR, 8'h08);
    check("abort_err", frame_err_o, 1'b1);
    check("abort_state", dbg_state_o, ST_ABORT);
    data_word();
    check("abort_err_once", frame_err_o, 1'b0);
    check("abort_hold", dbg_state_o, ST_ABORT);
    cyc(W_TERM, 8'hFF);
    check("abort_idle", dbg_state_o, ST_IDLE);
    check("abort_no_push", bus.ts_count_o, 5'd0);

    // restart: second start before terminate
    set_rtc(48'h50, 32'd5000, 16'h0077);
    cyc(W_S0, 8'h01);
    data_word();
    data_word();
    check("rs_base16", eth_count_base_o, 11'd16);
    set_rtc(48'h51, 32'd6000, 16'h0078);
    cyc(W_S0, 8'h01);
    check("rs_err", frame_err_o, 1'b1);
    check("rs_sfd", get_sfd_done_o, 1'b1);
    check("rs_base0", eth_count_base_o, 11'd0);
    check("rs_ts", sfd_timestamp_o, {48'h51, 32'd6000});
    data_word();
    check("rs_base8", eth_count_base_o, 11'd8);
    check("rs_err_once", frame_err_o, 1'b0);
    cyc(W_TERM, 8'hFF);
    exp_q.push_back(entry(16'h5555, 4'd0, 48'h51, 32'd6000, 16'h0078));
    check("rs_count", bus.ts_count_o, 5'd1);
    check("rs_head", bus.ts_data_o, exp_q[0]);

    // clock enable low: inputs ignored, state held
    tx_clk_en_i = 1'b0;
    bus.ts_rd_i = 1'b1;
    cyc(W_S0, 8'h01);
    check("en_no_sfd", get_sfd_done_o, 1'b0);
    check("en_state", dbg_state_o, ST_IDLE);
    check("en_no_pop", bus.ts_count_o, 5'd1);
    bus.ts_rd_i = 1'b0;
    tx_clk_en_i = 1'b1;
    cyc(W_IDLE, 8'hFF);

    // long frame: base saturates once
    is_ptp_message_i = 1'b0;
    cyc(W_S0, 8'h01);
    err_cnt = 0;
    for (int k = 0; k < 263; k++) begin
      data_word();
      if (frame_err_o === 1'b1) err_cnt++;
    end
    check("sat_base", eth_count_base_o, 11'h7F8);
    check("sat_err_pulses", err_cnt, 1);
    check("sat_active", frame_active_o, 1'b1);

    // asynchronous reset mid-frame
    @(negedge tx_clk);
    tx_rst_n = 1'b0;
    #1;
    exp_q.delete();
    check("mr_base", eth_count_base_o, 11'd0);
    check("mr_active", frame_active_o, 1'b0);
    check("mr_ts", {sfd_timestamp_o, sfd_timestamp_frac_ns_o}, 96'd0);
    check("mr_count", bus.ts_count_o, 5'd0);
    check("mr_valid", bus.ts_valid_o, 1'b0);
    check("mr_state", dbg_state_o, ST_IDLE);
    @(negedge tx_clk);
    tx_rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      data_word();
      check("mr_no_count", eth_count_base_o, 11'd0);
      check("mr_no_active", frame_active_o, 1'b0);
    end
    cyc(W_S0, 8'h01);
    check("mr_restart_sfd", get_sfd_done_o, 1'b1);
    cyc(W_TERM, 8'hFF);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
